// File: rtl/neuron_update_scheduler.sv
// Time-multiplexes one shared potential adder across NUM_NEURONS neurons, once per timestep.
// Holds per-neuron potentials and spikes, plus the adder configuration registers.

module neuron_slot #(
  parameter logic [31:0] RESET_POTENTIAL = 32'h0000_0000
) (
  input  logic        CLK_Slot,
  input  logic        RESETN_Slot,
  input  logic        we,
  input  logic        clr,
  input  logic [31:0] wdata,
  input  logic        spike_in,
  output logic [31:0] pot,
  output logic        spk
);
  always_ff @(posedge CLK_Slot) begin
    if (!RESETN_Slot) begin
      pot <= RESET_POTENTIAL;
      spk <= 1'b0;
    end else if (we) begin
      pot <= wdata;
      spk <= spike_in;
    end else if (clr) begin
      spk <= 1'b0;
    end
  end
endmodule

module neuron_update_scheduler #(
  parameter int          NUM_NEURONS     = 10,
  parameter int          IDX_W           = 4,
  parameter int          ADDER_LATENCY   = 2,
  parameter logic [31:0] RESET_POTENTIAL = 32'h0000_0000
) (
  input  logic                   CLK_Scheduler,
  input  logic                   RESETN_Scheduler,
  input  logic                   timestep_start,
  output logic                   busy,
  output logic                   timestep_done,
  output logic [NUM_NEURONS-1:0] spike_vector,
  output logic                   overrun,
  input  logic                   cfg_we,
  input  logic [2:0]             cfg_addr,
  input  logic [31:0]            cfg_wdata,
  output logic [31:0]            v_threshold,
  output logic [31:0]            a,
  output logic [31:0]            b,
  output logic [31:0]            c,
  output logic [31:0]            d,
  output logic [1:0]             model,
  output logic                   weight_req,
  output logic [IDX_W-1:0]       weight_idx,
  input  logic                   weight_ack,
  input  logic [31:0]            weight_data,
  output logic [31:0]            adder_input_weight,
  output logic [31:0]            adder_decayed_potential,
  input  logic [31:0]            adder_final_potential,
  input  logic                   adder_spike,
  input  logic [IDX_W-1:0]       rd_idx,
  output logic [31:0]            rd_potential
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_WB    = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]                   state;
  logic [IDX_W-1:0]             idx;
  logic [3:0]                   wcnt;
  logic [NUM_NEURONS-1:0][31:0] pot_all;
  logic [NUM_NEURONS-1:0]       shadow;
  logic [31:0]                  cur_pot;
  logic                         start_ok, cfg_ok, last;

  assign start_ok      = (state == S_IDLE) && timestep_start;
  assign cfg_ok        = (state == S_IDLE) && cfg_we;
  assign last          = (idx == IDX_W'(NUM_NEURONS-1));
  assign busy          = (state != S_IDLE);
  assign timestep_done = (state == S_DONE);
  assign weight_req    = (state == S_ISSUE);
  assign weight_idx    = idx;

  // Explicit mux so an out-of-range index reads as zero rather than X.
  always_comb begin
    rd_potential = '0;
    cur_pot      = '0;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      if (rd_idx == IDX_W'(i)) rd_potential = pot_all[i];
      if (idx == IDX_W'(i))    cur_pot      = pot_all[i];
    end
  end

  for (genvar g = 0; g < NUM_NEURONS; g++) begin : g_slot
    neuron_slot #(.RESET_POTENTIAL(RESET_POTENTIAL)) u_slot (
      .CLK_Slot    (CLK_Scheduler),
      .RESETN_Slot (RESETN_Scheduler),
      .we          ((state == S_WB) && (idx == IDX_W'(g))),
      .clr         (start_ok),
      .wdata       (adder_final_potential),
      .spike_in    (adder_spike),
      .pot         (pot_all[g]),
      .spk         (shadow[g])
    );
  end

  // WAIT lasts exactly ADDER_LATENCY cycles: counter loads LATENCY-1 and exits at zero.
  always_ff @(posedge CLK_Scheduler) begin
    if (!RESETN_Scheduler) begin
      state                   <= S_IDLE;
      idx                     <= '0;
      wcnt                    <= '0;
      adder_input_weight      <= '0;
      adder_decayed_potential <= '0;
      spike_vector            <= '0;
    end else begin
      case (state)
        S_IDLE: if (timestep_start) begin
          state <= S_ISSUE;
          idx   <= '0;
        end
        S_ISSUE: if (weight_ack) begin
          adder_input_weight      <= weight_data;
          adder_decayed_potential <= cur_pot;
          wcnt                    <= 4'(ADDER_LATENCY-1);
          state                   <= S_WAIT;
        end
        S_WAIT: begin
          if (wcnt == 4'd0) state <= S_WB;
          else              wcnt  <= wcnt - 4'd1;
        end
        S_WB: begin
          if (last) state <= S_DONE;
          else begin
            idx   <= idx + 1'b1;
            state <= S_ISSUE;
          end
        end
        S_DONE: begin
          spike_vector <= shadow;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_Scheduler) begin
    if (!RESETN_Scheduler) begin
      v_threshold <= 32'h4348_0000;
      model       <= 2'b00;
      a           <= '0;
      b           <= '0;
      c           <= '0;
      d           <= '0;
      overrun     <= 1'b0;
    end else begin
      if (cfg_ok) begin
        case (cfg_addr)
          3'd0: v_threshold <= cfg_wdata;
          3'd1: model       <= cfg_wdata[1:0];
          3'd2: a           <= cfg_wdata;
          3'd3: b           <= cfg_wdata;
          3'd4: c           <= cfg_wdata;
          3'd5: d           <= cfg_wdata;
          default: ;
        endcase
      end
      if (timestep_start && (state != S_IDLE))    overrun <= 1'b1;
      else if (cfg_ok && (cfg_addr == 3'd7))      overrun <= 1'b0;
    end
  end
endmodule
